// File: rtl/qspi_flash_responder.sv
// SPI-mode-0 flash target: oversamples csb/sclk/sd on clk_i, decodes READ, QUAD READ,
// PAGE PROGRAM, RDSR, WREN and WRDI, and serves data through a byte-wide memory port.
module qspi_flash_responder #(
  parameter int unsigned AW        = 24,
  parameter int unsigned DUMMY_CYC = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sclk_i,
  input  logic          csb_i,
  input  logic [3:0]    sd_i,
  output logic [3:0]    sd_o,
  output logic [3:0]    sd_oe_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i
);

  localparam int unsigned CW = $clog2(AW + DUMMY_CYC + 9);
  localparam logic [CW-1:0] BYTE_LAST  = CW'(7);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(AW - 1);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_CYC - 1);

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_QRDATA, S_WDATA, S_STATUS, S_IGNORE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sclk_sync_q, sclk_sync_d;
  logic [1:0]    csb_sync_q, csb_sync_d;
  logic [3:0]    sd_s1_q, sd_s1_d;
  logic [3:0]    sd_s2_q, sd_s2_d;
  logic          sclk_prev_q, sclk_prev_d;
  logic          csb_prev_q, csb_prev_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]    tot_cnt_q, tot_cnt_d;
  logic [AW-1:0] shift_q, shift_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    rbuf_q, rbuf_d;
  logic [7:0]    tx_q, tx_d;
  logic [2:0]    out_idx_q, out_idx_d;
  logic          rd_lat_q, rd_lat_d;
  logic          wel_q, wel_d;
  logic          set_pend_q, set_pend_d;
  logic          clr_pend_q, clr_pend_d;
  logic          wseen_q, wseen_d;
  logic [3:0]    sd_o_q, sd_o_d;
  logic [3:0]    sd_oe_q, sd_oe_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;

  logic          sclk_s, csb_s, rise, fall, csb_rise, csb_fall;
  logic [AW-1:0] shift_in;
  logic [7:0]    status_byte;
  logic          unused_sd;

  assign sclk_s      = sclk_sync_q[1];
  assign csb_s       = csb_sync_q[1];
  assign rise        = sclk_s & ~sclk_prev_q;
  assign fall        = ~sclk_s & sclk_prev_q;
  assign csb_rise    = csb_s & ~csb_prev_q;
  assign csb_fall    = ~csb_s & csb_prev_q;
  assign shift_in    = {shift_q[AW-2:0], sd_s2_q[0]};
  assign status_byte = {6'b0, wel_q, 1'b0};
  assign unused_sd   = ^sd_s2_q[3:1];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], sclk_i};
    csb_sync_d  = {csb_sync_q[0], csb_i};
    sd_s1_d     = sd_i;
    sd_s2_d     = sd_s1_q;
    sclk_prev_d = sclk_s;
    csb_prev_d  = csb_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tot_cnt_d   = tot_cnt_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    rbuf_d      = rbuf_q;
    tx_d        = tx_q;
    out_idx_d   = out_idx_q;
    wel_d       = wel_q;
    set_pend_d  = set_pend_q;
    clr_pend_d  = clr_pend_q;
    wseen_d     = wseen_q;
    sd_o_d      = sd_o_q;
    sd_oe_d     = sd_oe_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Read data arrives the cycle after the request strobe.
    rd_lat_d    = mem_req_q & ~mem_we_q;
    if (rd_lat_q) rbuf_d = mem_rdata_i;

    if (csb_rise) begin
      state_d    = S_IDLE;
      sd_oe_d    = '0;
      bit_cnt_d  = '0;
      out_idx_d  = '0;
      rd_lat_d   = 1'b0;
      rbuf_d     = rbuf_q;
      if (set_pend_q && tot_cnt_q == 4'd8) wel_d = 1'b1;
      if (clr_pend_q && tot_cnt_q == 4'd8) wel_d = 1'b0;
      if (wseen_q) wel_d = 1'b0;
      set_pend_d = 1'b0;
      clr_pend_d = 1'b0;
      wseen_d    = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (csb_fall) begin
        state_d   = S_CMD;
        bit_cnt_d = '0;
        tot_cnt_d = '0;
        out_idx_d = '0;
      end
    end else begin
      if (rise && tot_cnt_q != 4'hF) tot_cnt_d = tot_cnt_q + 4'd1;
      unique case (state_q)
        S_CMD: if (rise) begin
          shift_d = shift_in;
          if (bit_cnt_q == BYTE_LAST) begin
            bit_cnt_d = '0;
            cmd_d     = shift_in[7:0];
            out_idx_d = '0;
            case (shift_in[7:0])
              OP_READ, OP_QREAD: state_d = S_ADDR;
              OP_PP:   state_d = wel_q ? S_ADDR : S_IGNORE;
              OP_RDSR: begin
                state_d = S_STATUS;
                sd_oe_d = 4'b0010;
              end
              OP_WREN: begin
                state_d    = S_IGNORE;
                set_pend_d = 1'b1;
              end
              OP_WRDI: begin
                state_d    = S_IGNORE;
                clr_pend_d = 1'b1;
              end
              default: state_d = S_IGNORE;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_ADDR: if (rise) begin
          shift_d = shift_in;
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
            addr_d    = shift_in;
            out_idx_d = '0;
            case (cmd_q)
              OP_READ: begin
                mem_req_d  = 1'b1;
                mem_addr_d = shift_in;
                state_d    = S_RDATA;
                sd_oe_d    = 4'b0010;
              end
              OP_QREAD: begin
                mem_req_d  = 1'b1;
                mem_addr_d = shift_in;
                if (DUMMY_CYC == 0) begin
                  state_d = S_QRDATA;
                  sd_oe_d = 4'b1111;
                end else begin
                  state_d = S_DUMMY;
                end
              end
              OP_PP: begin
                state_d = S_WDATA;
                wseen_d = 1'b1;
              end
              default: state_d = S_IGNORE;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_DUMMY: if (rise) begin
          if (bit_cnt_q == DUMMY_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_QRDATA;
            sd_oe_d   = 4'b1111;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_RDATA: if (fall) begin
          // Bit 7 comes straight from the fetch buffer, which is then freed for the prefetch.
          if (out_idx_q == 3'd0) begin
            sd_o_d     = {2'b00, rbuf_q[7], 1'b0};
            tx_d       = rbuf_q;
            addr_d     = addr_q + 1'b1;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q + 1'b1;
          end else begin
            sd_o_d = {2'b00, tx_q[3'd7 - out_idx_q], 1'b0};
          end
          out_idx_d = out_idx_q + 3'd1;
        end
        S_QRDATA: if (fall) begin
          if (!out_idx_q[0]) begin
            sd_o_d     = rbuf_q[7:4];
            tx_d       = rbuf_q;
            addr_d     = addr_q + 1'b1;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q + 1'b1;
          end else begin
            sd_o_d = tx_q[3:0];
          end
          out_idx_d = {2'b00, ~out_idx_q[0]};
        end
        S_WDATA: if (rise) begin
          shift_d = shift_in;
          if (bit_cnt_q == BYTE_LAST) begin
            bit_cnt_d   = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = shift_in[7:0];
            addr_d      = addr_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_STATUS: if (fall) begin
          sd_o_d    = {2'b00, status_byte[3'd7 - out_idx_q], 1'b0};
          out_idx_d = out_idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      csb_sync_q  <= '1;
      sd_s1_q     <= '0;
      sd_s2_q     <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      tot_cnt_q   <= '0;
      shift_q     <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      rbuf_q      <= '0;
      tx_q        <= '0;
      out_idx_q   <= '0;
      rd_lat_q    <= 1'b0;
      wel_q       <= 1'b0;
      set_pend_q  <= 1'b0;
      clr_pend_q  <= 1'b0;
      wseen_q     <= 1'b0;
      sd_o_q      <= '0;
      sd_oe_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      csb_sync_q  <= csb_sync_d;
      sd_s1_q     <= sd_s1_d;
      sd_s2_q     <= sd_s2_d;
      sclk_prev_q <= sclk_prev_d;
      csb_prev_q  <= csb_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      tot_cnt_q   <= tot_cnt_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      rbuf_q      <= rbuf_d;
      tx_q        <= tx_d;
      out_idx_q   <= out_idx_d;
      rd_lat_q    <= rd_lat_d;
      wel_q       <= wel_d;
      set_pend_q  <= set_pend_d;
      clr_pend_q  <= clr_pend_d;
      wseen_q     <= wseen_d;
      sd_o_q      <= sd_o_d;
      sd_oe_q     <= sd_oe_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign sd_o        = sd_o_q;
  assign sd_oe_o     = sd_oe_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: drives SPI-mode-0 transactions and checks them
// against a byte-level flash model (memory contents, WEL, expected write list).
module tb_qspi_flash_responder;
  localparam int unsigned AW = 24;
  localparam int unsigned DC = 8;
  localparam int H = 6;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          sclk_i = 1'b0;
  logic          csb_i = 1'b1;
  logic [3:0]    sd_i = '0;
  logic [3:0]    sd_o, sd_oe_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_wdata_o;
  logic [7:0]    mem_rdata_i = '0;

  always #5 clk = ~clk;

  qspi_flash_responder #(.AW(AW), .DUMMY_CYC(DC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .sclk_i(sclk_i), .csb_i(csb_i), .sd_i(sd_i),
    .sd_o(sd_o), .sd_oe_o(sd_oe_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;

  logic [7:0]    dev_mem [int unsigned];
  logic [7:0]    ref_mem [int unsigned];
  wr_t           wr_log[$];
  logic [AW-1:0] rd_log[$];
  int            oe_nz = 0;
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic          wel_m = 1'b0;

  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Memory port: data valid only in the cycle after a read strobe, noise otherwise.
  always @(posedge clk) begin
    if (mem_req_o && mem_we_o) begin
      dev_mem[mem_addr_o] = mem_wdata_o;
      wr_log.push_back('{a: mem_addr_o, d: mem_wdata_o});
      mem_rdata_i <= 8'($urandom);
    end else if (mem_req_o) begin
      mem_rdata_i <= dev_rd(mem_addr_o);
      rd_log.push_back(mem_addr_o);
    end else begin
      mem_rdata_i <= 8'($urandom);
    end
  end

  always @(negedge clk) if (sd_oe_o != 4'b0) oe_nz++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic bit_x(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    sd_i = din;
    repeat (H) @(negedge clk);
    dout = sd_o;
    oe = sd_oe_o;
    sclk_i = 1'b1;
    repeat (H) @(negedge clk);
    sclk_i = 1'b0;
  endtask

  task automatic tx_bits(input logic [31:0] v, input int n, output logic [3:0] last_oe);
    logic [3:0] d;
    last_oe = '0;
    for (int i = n - 1; i >= 0; i--) bit_x({3'b000, v[i]}, d, last_oe);
  endtask

  task automatic rx_byte1(output logic [7:0] b, output logic [3:0] oe_first);
    logic [3:0] d, o;
    oe_first = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_x(4'b0, d, o);
      b[i] = d[1];
      if (i == 7) oe_first = o;
    end
  endtask

  task automatic rx_byte4(output logic [7:0] b, output logic [3:0] oe_first);
    logic [3:0] d, o;
    bit_x(4'b0, d, oe_first);
    b[7:4] = d;
    bit_x(4'b0, d, o);
    b[3:0] = d;
  endtask

  task automatic cs_lo();
    csb_i = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (H) @(negedge clk);
    csb_i = 1'b1;
    sd_i = '0;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic do_cmd_only(input logic [7:0] op, input int extra);
    logic [3:0] o;
    cs_lo();
    tx_bits({24'b0, op}, 8, o);
    if (extra > 0) tx_bits($urandom, extra, o);
    cs_hi();
    if (extra == 0 && op == 8'h06) wel_m = 1'b1;
    if (extra == 0 && op == 8'h04) wel_m = 1'b0;
  endtask

  task automatic do_rdsr(input int nbytes, input string tag);
    logic [3:0] o;
    logic [7:0] b;
    cs_lo();
    tx_bits(32'h05, 8, o);
    for (int i = 0; i < nbytes; i++) begin
      rx_byte1(b, o);
      check($sformatf("%s_sr%0d", tag, i), {24'b0, b}, {24'b0, 6'b0, wel_m, 1'b0});
    end
    cs_hi();
  endtask

  // Every byte boundary fetches one byte ahead, including the boundary after the last byte.
  task automatic check_reads(input string tag, input logic [AW-1:0] addr, input int n);
    check({tag, "_nreq"}, rd_log.size(), n + 2);
    for (int i = 0; i < rd_log.size() && i < n + 2; i++)
      check($sformatf("%s_ra%0d", tag, i), {8'b0, rd_log[i]}, {8'b0, addr + AW'(i)});
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int n, input string tag);
    logic [3:0] o, o_first;
    logic [7:0] b;
    rd_log.delete();
    cs_lo();
    tx_bits(32'h03, 8, o);
    tx_bits({8'b0, addr}, AW, o);
    check({tag, "_oe_addr"}, {28'b0, o}, 32'h0);
    for (int i = 0; i < n; i++) begin
      rx_byte1(b, o_first);
      if (i == 0) check({tag, "_oe_data"}, {28'b0, o_first}, 32'h2);
      check($sformatf("%s_b%0d", tag, i), {24'b0, b}, {24'b0, ref_rd(addr + AW'(i))});
    end
    cs_hi();
    check_reads(tag, addr, n);
  endtask

  task automatic do_qread(input logic [AW-1:0] addr, input int n, input string tag);
    logic [3:0] o, o_first;
    logic [7:0] b;
    rd_log.delete();
    cs_lo();
    tx_bits(32'h6B, 8, o);
    tx_bits({8'b0, addr}, AW, o);
    tx_bits(32'h0, DC, o);
    check({tag, "_oe_dummy"}, {28'b0, o}, 32'h0);
    for (int i = 0; i < n; i++) begin
      rx_byte4(b, o_first);
      if (i == 0) check({tag, "_oe_data"}, {28'b0, o_first}, 32'hF);
      check($sformatf("%s_b%0d", tag, i), {24'b0, b}, {24'b0, ref_rd(addr + AW'(i))});
    end
    cs_hi();
    check_reads(tag, addr, n);
  endtask

  task automatic do_program(input logic [AW-1:0] addr, input logic [7:0] data[$], input int extra,
                            input string tag);
    logic [3:0] o;
    wr_t exp_q[$];
    wr_log.delete();
    rd_log.delete();
    cs_lo();
    oe_nz = 0;
    tx_bits(32'h02, 8, o);
    tx_bits({8'b0, addr}, AW, o);
    foreach (data[i]) tx_bits({24'b0, data[i]}, 8, o);
    if (extra > 0) tx_bits($urandom, extra, o);
    cs_hi();
    if (wel_m) begin
      foreach (data[i]) begin
        exp_q.push_back('{a: addr + AW'(i), d: data[i]});
        ref_mem[addr + AW'(i)] = data[i];
      end
      wel_m = 1'b0;
    end
    check({tag, "_nreq"}, wr_log.size() + rd_log.size(), exp_q.size());
    check({tag, "_oe"}, oe_nz, 0);
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      check($sformatf("%s_wa%0d", tag, i), {8'b0, wr_log[i].a}, {8'b0, exp_q[i].a});
      check($sformatf("%s_wd%0d", tag, i), {24'b0, wr_log[i].d}, {24'b0, exp_q[i].d});
    end
  endtask

  initial begin
    logic [7:0]    bytes[$];
    logic [AW-1:0] a;
    logic [3:0]    o, d;
    logic [7:0]    b;
    int            n;

    repeat (5) @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sd_o", {28'b0, sd_o}, 0);
    check("rst_sd_oe", {28'b0, sd_oe_o}, 0);
    check("rst_req", {31'b0, mem_req_o}, 0);
    check("rst_we", {31'b0, mem_we_o}, 0);
    check("rst_addr", {8'b0, mem_addr_o}, 0);
    check("rst_wdata", {24'b0, mem_wdata_o}, 0);
    do_rdsr(1, "rst");

    do_cmd_only(8'h06, 0);
    do_rdsr(2, "wren");
    do_cmd_only(8'h04, 0);
    do_rdsr(1, "wrdi");
    do_cmd_only(8'h06, 1);
    do_rdsr(1, "wren9");

    poke(24'h000100, 8'hA5);
    poke(24'h000101, 8'h3C);
    do_read(24'h000100, 2, "read");

    poke(24'hFFFFFF, 8'h12);
    poke(24'h000000, 8'h34);
    do_qread(24'hFFFFFF, 2, "qwrap");

    do_cmd_only(8'h06, 0);
    bytes = '{8'hDE, 8'hAD};
    do_program(24'h000010, bytes, 3, "pp");
    do_rdsr(1, "pp_wel");
    do_read(24'h000010, 2, "pp_rb");

    bytes = '{8'h55};
    do_program(24'h000200, bytes, 0, "prot");

    cs_lo();
    tx_bits(32'h03, 8, o);
    tx_bits(32'h000100, AW, o);
    for (int i = 0; i < 3; i++) bit_x(4'b0, d, o);
    check("abort_oe_before", {28'b0, sd_oe_o}, 32'h2);
    csb_i = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_oe", {28'b0, sd_oe_o}, 0);
    repeat (2 * H) @(negedge clk);
    do_cmd_only(8'h06, 0);
    do_rdsr(1, "abort_next");

    for (int k = 0; k < 4; k++) begin
      a = AW'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) do_qread(a, n, $sformatf("rq%0d", k));
      else do_read(a, n, $sformatf("rs%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      a = AW'($urandom);
      n = $urandom_range(1, 3);
      bytes.delete();
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
      do_cmd_only(8'h06, 0);
      do_program(a, bytes, $urandom_range(0, 7), $sformatf("rp%0d", k));
      do_read(a, n, $sformatf("rpb%0d", k));
    end

    do_cmd_only(8'h06, 0);
    cs_lo();
    tx_bits(32'h6B, 8, o);
    tx_bits(32'h00ABCD, AW, o);
    tx_bits(32'h0, DC, o);
    rx_byte4(b, o);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("mrst_sd_o", {28'b0, sd_o}, 0);
    check("mrst_sd_oe", {28'b0, sd_oe_o}, 0);
    check("mrst_req", {31'b0, mem_req_o}, 0);
    check("mrst_we", {31'b0, mem_we_o}, 0);
    check("mrst_addr", {8'b0, mem_addr_o}, 0);
    check("mrst_wdata", {24'b0, mem_wdata_o}, 0);
    csb_i = 1'b1;
    sclk_i = 1'b0;
    sd_i = '0;
    repeat (4) @(negedge clk);
    rst_ni = 1'b1;
    wel_m = 1'b0;
    repeat (4) @(negedge clk);
    do_rdsr(1, "mrst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- SPI-mode-0 flash target: the device end of the bus driven by the QSPI flash controller.
- Decodes commands, addresses and data from the controller's csb/sclk/io pins and serves reads and page programs from a byte-wide memory port.
- Used as the synthesizable flash model in controller testbenches and FPGA loopback builds.
- sclk/csb/sd are oversampled on clk_i: sclk high and low phases must each be at least 4 clk_i cycles.

Parameters:
- AW, 24, flash byte-address width.
- DUMMY_CYC, 8, dummy sclk cycles for quad output read (0x6B).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- sclk_i  in  1  serial clock from controller
- csb_i  in  1  chip select, active low
- sd_i  in  4  io lines from controller
- sd_o  out  4  io lines to controller
- sd_oe_o  out  4  per-line output enable
- mem_req_o  out  1  one-cycle memory access strobe
- mem_we_o  out  1  write qualifier for mem_req_o
- mem_addr_o  out  AW  byte address
- mem_wdata_o  out  8  write byte
- mem_rdata_i  in  8  read byte, valid the cycle after mem_req_o

Behaviour:
- Reset values: sd_o=0, sd_oe_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, WEL=0, state=IDLE.
- Input sampling:
  - sclk_i, csb_i and sd_i pass through a 2-flop synchronizer.
  - Rise/fall events are detected on synchronized sclk.
  - Bits are captured from synchronized sd on rise events.
  - Outputs update on fall events.
- MSB first throughout. Single-line input uses sd_i[0]; single-line output uses sd_o[1].
- States: IDLE, CMD, ADDR, DUMMY, RDATA, QRDATA, WDATA, STATUS, IGNORE.
- IDLE -> CMD when synchronized csb goes low; bit counter cleared.
- CMD: shift in 8 bits, then decode:
  - 0x03 and 0x6B -> ADDR.
  - 0x02 -> ADDR if WEL=1, else IGNORE.
  - 0x05 -> STATUS.
  - 0x06 and 0x04 -> IGNORE, with a pending set-WEL (0x06) or clear-WEL (0x04) flag.
  - Any other opcode -> IGNORE.
- ADDR: shift in AW bits.
  - On the last bit, load the address counter.
  - 0x03: issue a read mem_req_o -> RDATA.
  - 0x6B: issue a read mem_req_o -> DUMMY.
  - 0x02 -> WDATA.
- DUMMY: count DUMMY_CYC rise events, then go to QRDATA.
- RDATA:
  - sd_oe_o=4'b0010; drive one bit per fall event.
  - The byte is latched from mem_rdata_i the cycle after the request.
  - On the fall that drives bit 7, the address increments and the next read is requested (prefetch).
- QRDATA:
  - sd_oe_o=4'b1111; drive one nibble per fall event, high nibble first.
  - Prefetch on the fall that drives the high nibble.
  - The first nibble is driven on the first fall after the dummy phase.
- WDATA:
  - Every 8 rise events form a byte.
  - Each complete byte issues mem_req_o=1 and mem_we_o=1 for one cycle at the current address, then the address increments.
- STATUS: drive status byte {6'b0, WEL, 1'b0} (WIP always 0), repeating while csb is low.
- Address counter is AW bits and wraps from all-ones to 0.
- Synchronized csb rising, from any state:
  - Go to IDLE; sd_oe_o=0 in the same cycle.
  - The bit counter resets; a partially received write byte is discarded.
  - An in-flight read response is dropped.
- WEL update at csb rise:
  - Pending set flag applies only if exactly 8 command bits were received.
  - Pending clear flag applies likewise.
  - WEL clears if any 0x02 transaction reached WDATA.
- csb rise and sclk edge in the same cycle: csb takes priority; the edge is ignored.
- Asynchronous reset mid-transaction returns every register to its reset value immediately.
- Latency:
  - mem_req_o asserts 1 clk_i after the rise event that completes the address or data byte.
  - sd_o updates 1 clk_i after the fall event is detected.

Test Plan:
- Write enable: csb low, opcode 0x06, csb high; then 0x05 -> status reads 0x02. Repeat with 0x04 -> status reads 0x00.
- Single read: memory preloaded 0x000100=0xA5, 0x000101=0x3C; 0x03 with address 0x000100, 16 sclk -> sd_o[1] stream 0xA5,0x3C; sd_oe_o=0010 only after the last address bit.
- Quad read with wrap: memory 0xFFFFFF=0x12, 0x000000=0x34; 0x6B with address 0xFFFFFF, 8 dummy cycles, 4 sclk -> nibbles 1,2,3,4; mem_addr_o wraps to 0.
- Program: 0x06; then 0x02 with address 0x000010, bytes 0xDE,0xAD, plus 3 extra bits before csb high -> exactly two writes (0x10=0xDE, 0x11=0xAD); afterwards WEL=0.
- Protection: 0x02 with WEL=0 -> no mem_req_o; sd_oe_o stays 0.
- Abort and reset:
  - csb high mid-byte during 0x03 -> sd_oe_o=0 in the same cycle; the next transaction decodes correctly.
  - rst_ni low mid-transaction -> all outputs return to reset values.
